// File: rtl/ee354_project_dir_queue_if.sv
// Bundle of direction-queue signals between the button debouncers / game FSM
// (master side) and the direction queue (slave side).
interface ee354_project_dir_queue_if #(
  parameter int PTR_W = 2
);
  logic             BtnU_SCEN;
  logic             BtnD_SCEN;
  logic             BtnL_SCEN;
  logic             BtnR_SCEN;
  logic             q_Run;
  logic             Tick;
  logic [1:0]       Cur_Dirn;
  logic             Dirn_Changed;
  logic             Drop;
  logic [PTR_W:0]   Count;
  logic             Empty;
  logic             Full;

  modport master (
    output BtnU_SCEN, BtnD_SCEN, BtnL_SCEN, BtnR_SCEN, q_Run, Tick,
    input  Cur_Dirn, Dirn_Changed, Drop, Count, Empty, Full
  );

  modport slave (
    input  BtnU_SCEN, BtnD_SCEN, BtnL_SCEN, BtnR_SCEN, q_Run, Tick,
    output Cur_Dirn, Dirn_Changed, Drop, Count, Empty, Full
  );
endinterface

// File: rtl/ee354_project_dir_queue.sv
// Direction-command queue for the snake game. Single-cycle button pulses are
// filtered against the most recent direction (duplicates and reversals are
// dropped), buffered in a small circular queue, and released one per game
// tick into the registered current direction.
module ee354_project_dir_queue #(
  parameter int         DEPTH     = 4,
  parameter int         PTR_W     = 2,
  parameter logic [1:0] INIT_DIRN = 2'b11
) (
  input  logic                     Clk,
  input  logic                     Reset,
  ee354_project_dir_queue_if.slave bus
);

  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  logic [1:0]       r_mem [DEPTH];
  logic [1:0]       r_cur;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_changed;
  logic             r_drop;

  logic             w_press;
  logic [1:0]       w_cand;
  logic [PTR_W-1:0] w_tailPtr;
  logic [1:0]       w_ref;
  logic             w_full;
  logic             w_pop;
  logic             w_dup;
  logic             w_opp;
  logic             w_accept;
  logic             w_drop;

  assign w_press   = bus.BtnU_SCEN | bus.BtnD_SCEN | bus.BtnL_SCEN | bus.BtnR_SCEN;
  assign w_tailPtr = r_wptr - 1'b1;
  assign w_ref     = (r_count != '0) ? r_mem[w_tailPtr] : r_cur;
  assign w_full    = (r_count == C_DEPTH);
  assign w_pop     = bus.q_Run & bus.Tick & (r_count != '0);
  assign w_dup     = (w_cand == w_ref);
  assign w_opp     = (w_cand[1] == w_ref[1]) & (w_cand[0] != w_ref[0]);
  assign w_accept  = bus.q_Run & w_press & ~w_dup & ~w_opp & (~w_full | w_pop);
  assign w_drop    = bus.q_Run & w_press & ~w_accept;

  // Pick one press per cycle with fixed priority U > D > L > R.
  always_comb begin
    w_cand = 2'b11;
    if (bus.BtnU_SCEN)      w_cand = 2'b00;
    else if (bus.BtnD_SCEN) w_cand = 2'b01;
    else if (bus.BtnL_SCEN) w_cand = 2'b10;
    else                    w_cand = 2'b11;
  end

  // Queue storage: contents are don't-care until counted, so no reset needed.
  always_ff @(posedge Clk) begin
    if (w_accept) r_mem[r_wptr] <= w_cand;
  end

  // Pointers, occupancy, current direction and the one-cycle status pulses.
  always_ff @(posedge Clk) begin
    if (Reset || !bus.q_Run) begin
      r_cur     <= INIT_DIRN;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_changed <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_changed <= w_pop;
      r_drop    <= w_drop;
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_cur  <= r_mem[r_rptr];
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.Cur_Dirn     = r_cur;
  assign bus.Dirn_Changed = r_changed;
  assign bus.Drop         = r_drop;
  assign bus.Count        = r_count;
  assign bus.Empty        = (r_count == '0);
  assign bus.Full         = (r_count == C_DEPTH);

endmodule

// File: tb/tb_ee354_project_dir_queue.sv
// Directed bench for the snake direction queue: each scenario drives button
// and tick pulses for one clock and compares the full registered status word.
module tb_ee354_project_dir_queue;

  logic Clk;
  logic Reset;
  int   compared;
  int   mismatched;

  ee354_project_dir_queue_if #(.PTR_W(2)) bus ();

  ee354_project_dir_queue #(.DEPTH(4), .PTR_W(2), .INIT_DIRN(2'b11)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Observed status word: {Cur_Dirn, Dirn_Changed, Drop, Count, Empty, Full}.
  logic [8:0] obs;
  assign obs = {bus.Cur_Dirn, bus.Dirn_Changed, bus.Drop, bus.Count, bus.Empty, bus.Full};

  // Expected status word; Empty/Full follow from the expected count.
  function automatic logic [8:0] st(input logic [1:0] cur, input logic chg,
                                    input logic drp, input logic [2:0] cnt);
    return {cur, chg, drp, cnt, (cnt == 3'd0), (cnt == 3'd4)};
  endfunction

  // Hold the given pulses for exactly one rising edge, then sample 1 ns later.
  task automatic applyStimulus(input logic u, input logic d, input logic l,
                               input logic r, input logic t);
    bus.BtnU_SCEN = u; bus.BtnD_SCEN = d; bus.BtnL_SCEN = l;
    bus.BtnR_SCEN = r; bus.Tick = t;
    @(posedge Clk); #1;
    bus.BtnU_SCEN = 0; bus.BtnD_SCEN = 0; bus.BtnL_SCEN = 0;
    bus.BtnR_SCEN = 0; bus.Tick = 0;
  endtask

  task automatic doReset();
    Reset = 1'b1; bus.q_Run = 1'b1;
    applyStimulus(0,0,0,0,0);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    if (obs !== st(2'b11,0,0,3'd0)) begin $display("[TB] FAIL reset_state: observed %b expected %b", obs, st(2'b11,0,0,3'd0)); mismatched++; end compared++;
  endtask

  task automatic test_push_pop();
    doReset();
    applyStimulus(1,0,0,0,0);
    if (obs !== st(2'b11,0,0,3'd1)) begin $display("[TB] FAIL pp_pressU: observed %b expected %b", obs, st(2'b11,0,0,3'd1)); mismatched++; end compared++;
    applyStimulus(0,0,0,0,1);
    if (obs !== st(2'b00,1,0,3'd0)) begin $display("[TB] FAIL pp_tick: observed %b expected %b", obs, st(2'b00,1,0,3'd0)); mismatched++; end compared++;
    applyStimulus(0,0,0,0,0);
    if (obs !== st(2'b00,0,0,3'd0)) begin $display("[TB] FAIL pp_idle: observed %b expected %b", obs, st(2'b00,0,0,3'd0)); mismatched++; end compared++;
  endtask

  task automatic test_reject();
    doReset();
    applyStimulus(0,0,1,0,0);
    if (obs !== st(2'b11,0,1,3'd0)) begin $display("[TB] FAIL rej_opposite: observed %b expected %b", obs, st(2'b11,0,1,3'd0)); mismatched++; end compared++;
    applyStimulus(0,0,0,1,0);
    if (obs !== st(2'b11,0,1,3'd0)) begin $display("[TB] FAIL rej_dup: observed %b expected %b", obs, st(2'b11,0,1,3'd0)); mismatched++; end compared++;
    applyStimulus(0,1,0,0,0);
    if (obs !== st(2'b11,0,0,3'd1)) begin $display("[TB] FAIL rej_acceptD: observed %b expected %b", obs, st(2'b11,0,0,3'd1)); mismatched++; end compared++;
    applyStimulus(1,0,0,0,0);
    if (obs !== st(2'b11,0,1,3'd1)) begin $display("[TB] FAIL rej_tail_opp: observed %b expected %b", obs, st(2'b11,0,1,3'd1)); mismatched++; end compared++;
    applyStimulus(0,0,0,0,0);
    if (obs !== st(2'b11,0,0,3'd1)) begin $display("[TB] FAIL rej_drop_clear: observed %b expected %b", obs, st(2'b11,0,0,3'd1)); mismatched++; end compared++;
    applyStimulus(0,0,0,0,1);
    if (obs !== st(2'b01,1,0,3'd0)) begin $display("[TB] FAIL rej_tick: observed %b expected %b", obs, st(2'b01,1,0,3'd0)); mismatched++; end compared++;
  endtask

  task automatic test_full();
    logic [1:0] popOrder [4];
    popOrder = '{2'b00, 2'b10, 2'b01, 2'b11};
    doReset();
    applyStimulus(1,0,0,0,0);
    applyStimulus(0,0,1,0,0);
    applyStimulus(0,1,0,0,0);
    applyStimulus(0,0,0,1,0);
    if (obs !== st(2'b11,0,0,3'd4)) begin $display("[TB] FAIL full_fill: observed %b expected %b", obs, st(2'b11,0,0,3'd4)); mismatched++; end compared++;
    applyStimulus(1,0,0,0,0);
    if (obs !== st(2'b11,0,1,3'd4)) begin $display("[TB] FAIL full_drop: observed %b expected %b", obs, st(2'b11,0,1,3'd4)); mismatched++; end compared++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0,0,0,0,1);
      if (obs !== st(popOrder[i],1,0,3'(3-i))) begin $display("[TB] FAIL full_pop%0d: observed %b expected %b", i, obs, st(popOrder[i],1,0,3'(3-i))); mismatched++; end compared++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] popOrder [4];
    popOrder = '{2'b10, 2'b01, 2'b11, 2'b00};
    doReset();
    applyStimulus(1,0,0,0,0);
    applyStimulus(0,0,1,0,0);
    applyStimulus(0,1,0,0,0);
    applyStimulus(0,0,0,1,0);
    applyStimulus(1,0,0,0,1);
    if (obs !== st(2'b00,1,0,3'd4)) begin $display("[TB] FAIL b2b_push_pop_full: observed %b expected %b", obs, st(2'b00,1,0,3'd4)); mismatched++; end compared++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0,0,0,0,1);
      if (obs !== st(popOrder[i],1,0,3'(3-i))) begin $display("[TB] FAIL b2b_wrap_pop%0d: observed %b expected %b", i, obs, st(popOrder[i],1,0,3'(3-i))); mismatched++; end compared++;
    end
  endtask

  task automatic test_priority();
    doReset();
    applyStimulus(1,0,0,0,0);
    applyStimulus(0,0,0,0,1);
    applyStimulus(0,0,1,0,0);
    applyStimulus(0,0,0,0,1);
    if (obs !== st(2'b10,1,0,3'd0)) begin $display("[TB] FAIL prio_setup_left: observed %b expected %b", obs, st(2'b10,1,0,3'd0)); mismatched++; end compared++;
    applyStimulus(1,0,0,1,0);
    if (obs !== st(2'b10,0,0,3'd1)) begin $display("[TB] FAIL prio_U_over_R: observed %b expected %b", obs, st(2'b10,0,0,3'd1)); mismatched++; end compared++;
    applyStimulus(0,0,0,0,1);
    if (obs !== st(2'b00,1,0,3'd0)) begin $display("[TB] FAIL prio_popU: observed %b expected %b", obs, st(2'b00,1,0,3'd0)); mismatched++; end compared++;
    applyStimulus(0,0,0,0,1);
    if (obs !== st(2'b00,0,0,3'd0)) begin $display("[TB] FAIL prio_empty_tick: observed %b expected %b", obs, st(2'b00,0,0,3'd0)); mismatched++; end compared++;
  endtask

  task automatic test_flush();
    doReset();
    applyStimulus(1,0,0,0,0);
    applyStimulus(0,0,0,0,1);
    applyStimulus(0,0,1,0,0);
    applyStimulus(0,1,0,0,0);
    applyStimulus(0,0,0,1,0);
    if (obs !== st(2'b00,0,0,3'd3)) begin $display("[TB] FAIL flush_setup: observed %b expected %b", obs, st(2'b00,0,0,3'd3)); mismatched++; end compared++;
    bus.q_Run = 1'b0;
    applyStimulus(0,0,0,0,1);
    if (obs !== st(2'b11,0,0,3'd0)) begin $display("[TB] FAIL flush_clear: observed %b expected %b", obs, st(2'b11,0,0,3'd0)); mismatched++; end compared++;
    applyStimulus(1,0,0,0,0);
    if (obs !== st(2'b11,0,0,3'd0)) begin $display("[TB] FAIL flush_press_ignored: observed %b expected %b", obs, st(2'b11,0,0,3'd0)); mismatched++; end compared++;
    applyStimulus(0,0,1,0,0);
    if (obs !== st(2'b11,0,0,3'd0)) begin $display("[TB] FAIL flush_no_drop: observed %b expected %b", obs, st(2'b11,0,0,3'd0)); mismatched++; end compared++;
    bus.q_Run = 1'b1;
  endtask

  task automatic test_reset_mid();
    doReset();
    applyStimulus(1,0,0,0,0);
    applyStimulus(0,0,1,0,0);
    applyStimulus(0,0,0,0,1);
    if (obs !== st(2'b00,1,0,3'd1)) begin $display("[TB] FAIL rstmid_setup: observed %b expected %b", obs, st(2'b00,1,0,3'd1)); mismatched++; end compared++;
    applyStimulus(0,1,0,0,0);
    Reset = 1'b1;
    applyStimulus(0,0,0,0,1);
    Reset = 1'b0;
    if (obs !== st(2'b11,0,0,3'd0)) begin $display("[TB] FAIL rstmid_cleared: observed %b expected %b", obs, st(2'b11,0,0,3'd0)); mismatched++; end compared++;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    Reset = 1'b1;
    bus.q_Run = 1'b1;
    bus.BtnU_SCEN = 0; bus.BtnD_SCEN = 0; bus.BtnL_SCEN = 0;
    bus.BtnR_SCEN = 0; bus.Tick = 0;
    test_reset();
    test_push_pop();
    test_reject();
    test_full();
    test_back_to_back();
    test_priority();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
